// File: rtl/cr_iu_wb_ctrl.sv
// Writeback controller: owns the RF write port, tracks one outstanding load, raises EX stalls.
// Optional define CR_IU_WB_LOAD_FWD_EN forwards returning load data to EX in the return cycle.
module cr_iu_wb_ctrl #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              ex_wb_inst_vld,
  input  logic              ex_wb_src0_vld,
  input  logic              ex_wb_src1_vld,
  input  logic [REG_AW-1:0] ex_wb_src0_idx,
  input  logic [REG_AW-1:0] ex_wb_src1_idx,
  input  logic              ex_wb_dst_vld,
  input  logic [REG_AW-1:0] ex_wb_dst_idx,
  input  logic              ex_wb_lsu_sel,
  input  logic              ex_wb_lsu_issue,
  input  logic              ex_wb_alu_vld,
  input  logic [XLEN-1:0]   ex_wb_alu_data,
  input  logic              lsu_wb_data_vld,
  input  logic [XLEN-1:0]   lsu_wb_data,
  input  logic              lsu_wb_expt,
  output logic              wb_ctrl_stall,
  output logic              wb_rf_wen,
  output logic [REG_AW-1:0] wb_rf_widx,
  output logic [XLEN-1:0]   wb_rf_wdata,
  output logic              wb_fwd_vld,
  output logic [XLEN-1:0]   wb_fwd_data,
  output logic              wb_busy
);

`ifdef CR_IU_WB_LOAD_FWD_EN
  localparam bit LoadFwd = 1'b1;
`else
  localparam bit LoadFwd = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PEND, WRBK} state_e;

  state_e            state_q, state_d;
  logic [REG_AW-1:0] pend_idx_q, pend_idx_d;
  logic [XLEN-1:0]   buf_q, buf_d;

  logic pend_nz, src_hit, dst_hit, ret_good, ret_flt, alu_wr;

  assign pend_nz  = pend_idx_q != '0;
  assign src_hit  = ex_wb_inst_vld && pend_nz &&
                    ((ex_wb_src0_vld && ex_wb_src0_idx == pend_idx_q) ||
                     (ex_wb_src1_vld && ex_wb_src1_idx == pend_idx_q));
  assign dst_hit  = ex_wb_inst_vld && pend_nz && ex_wb_dst_vld && ex_wb_dst_idx == pend_idx_q;
  assign ret_good = state_q == PEND && lsu_wb_data_vld && !lsu_wb_expt;
  assign ret_flt  = state_q == PEND && lsu_wb_data_vld && lsu_wb_expt;
  assign alu_wr   = ex_wb_alu_vld && ex_wb_dst_idx != '0;

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q    <= IDLE;
      pend_idx_q <= '0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_idx_q <= pend_idx_d;
      buf_q      <= buf_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pend_idx_d    = pend_idx_q;
    buf_d         = buf_q;
    wb_ctrl_stall = 1'b0;
    wb_rf_wen     = 1'b0;
    wb_rf_widx    = '0;
    wb_rf_wdata   = '0;
    if (alu_wr) begin
      wb_rf_wen   = 1'b1;
      wb_rf_widx  = ex_wb_dst_idx;
      wb_rf_wdata = ex_wb_alu_data;
    end
    case (state_q)
      IDLE: begin
        if (ex_wb_lsu_issue) begin
          state_d    = PEND;
          pend_idx_d = ex_wb_dst_idx;
        end
      end
      PEND: begin
        if (ret_flt) begin
          state_d = IDLE;
        end else if (ret_good) begin
          // Serialisation term dropped; source terms only drop when the data is forwarded.
          wb_ctrl_stall = dst_hit || (!LoadFwd && src_hit);
          if (ex_wb_alu_vld) begin
            buf_d   = lsu_wb_data;
            state_d = WRBK;
          end else begin
            state_d = IDLE;
            if (pend_nz) begin
              wb_rf_wen   = 1'b1;
              wb_rf_widx  = pend_idx_q;
              wb_rf_wdata = lsu_wb_data;
            end
          end
        end else begin
          wb_ctrl_stall = src_hit || dst_hit || (ex_wb_inst_vld && ex_wb_lsu_sel);
        end
        // A back-to-back load issued in the return cycle re-arms PEND.
        if (lsu_wb_data_vld && ex_wb_lsu_issue && !ex_wb_alu_vld) begin
          state_d    = PEND;
          pend_idx_d = ex_wb_dst_idx;
        end
      end
      WRBK: begin
        wb_ctrl_stall = ex_wb_inst_vld;
        wb_rf_wen     = pend_nz;
        wb_rf_widx    = pend_nz ? pend_idx_q : '0;
        wb_rf_wdata   = pend_nz ? buf_q : '0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_fwd_vld  = LoadFwd && ret_good && pend_nz;
  assign wb_fwd_data = wb_fwd_vld ? lsu_wb_data : '0;
  assign wb_busy     = state_q != IDLE;

endmodule

// File: doc/cr_iu_wb_ctrl.md
Name: cr_iu_wb_ctrl

Overview:
- Writeback-stage controller directly downstream of the IU EX control stage.
- Owns the single register-file write port and arbitrates between single-cycle EX results (ALU/CP0/special) and one outstanding late LSU load return.
- Tracks the pending load destination and generates wb_ctrl_stall back to EX control for RAW/WAW hazards, a second load, or write-port conflicts.

Parameters:
XLEN, 32, data width of RF write/forward paths.
REG_AW, 5, register index width; index 0 is the hardwired zero register.

Ports:
forever_cpuclk  in  1  core clock.
cpurst_b  in  1  reset, synchronous, active-low.
ex_wb_inst_vld  in  1  valid instruction present in EX (pre-stall).
ex_wb_src0_vld / ex_wb_src1_vld  in  1  EX instruction reads src0/src1.
ex_wb_src0_idx / ex_wb_src1_idx  in  REG_AW  EX source indices.
ex_wb_dst_vld  in  1  EX instruction writes a destination.
ex_wb_dst_idx  in  REG_AW  EX destination index.
ex_wb_lsu_sel  in  1  EX instruction is a load (pre-stall).
ex_wb_lsu_issue  in  1  load issued this cycle; upstream guarantees 0 while wb_ctrl_stall=1.
ex_wb_alu_vld  in  1  single-cycle result valid; upstream guarantees 0 while wb_ctrl_stall=1.
ex_wb_alu_data  in  XLEN  single-cycle result; destination is ex_wb_dst_idx.
lsu_wb_data_vld  in  1  load data returned.
lsu_wb_data  in  XLEN  load data.
lsu_wb_expt  in  1  load faulted; qualifies lsu_wb_data_vld.
wb_ctrl_stall  out  1  stall request to EX control.
wb_rf_wen  out  1  RF write enable.
wb_rf_widx  out  REG_AW  RF write index.
wb_rf_wdata  out  XLEN  RF write data.
wb_fwd_vld  out  1  load data forwarded to EX this cycle (optional feature).
wb_fwd_data  out  XLEN  forwarded data.
wb_busy  out  1  load outstanding or buffered (state != IDLE).

Behaviour:
- Clocking and reset: all state updates on the rising edge of forever_cpuclk.
- Reset (cpurst_b=0 at an edge): state=IDLE, pend_idx=0, buffered data=0.
- Reset values: all outputs 0 (wb_rf_* are combinational from state/inputs, so they are also 0 in IDLE with no input).
- A reset taken in PEND drops the load; any later lsu_wb_data_vld seen in IDLE is ignored.
- FSM IDLE:
  - ex_wb_alu_vld && dst_idx!=0 -> wen=1, widx=dst_idx, wdata=alu_data, same cycle (0 latency).
  - ex_wb_lsu_issue -> PEND, pend_idx<=dst_idx. A load to x0 still goes to PEND but creates no register hazard.
- FSM PEND: hazard H = ex_wb_inst_vld && pend_idx!=0 && any of:
  - src0_vld && src0_idx==pend_idx;
  - src1_vld && src1_idx==pend_idx;
  - dst_vld && dst_idx==pend_idx.
- PEND stall: wb_ctrl_stall = H || (ex_wb_inst_vld && ex_wb_lsu_sel); only one load may be outstanding.
- Return cycle, good data (lsu_wb_data_vld && !lsu_wb_expt):
  - No ALU write this cycle: wen=1, widx=pend_idx, wdata=lsu_wb_data. Next state IDLE, or PEND with the new pend_idx if ex_wb_lsu_issue is asserted the same cycle.
  - The load-serialisation stall term is dropped in the return cycle, so back-to-back loads are allowed.
  - ALU write this cycle (ex_wb_alu_vld): ALU owns the port; load data is latched and the next state is WRBK.
  - WAW matches continue to stall through the return cycle.
- Return cycle, fault (lsu_wb_data_vld && lsu_wb_expt): no write; next state IDLE; stall drops the same cycle.
- FSM WRBK (1 cycle):
  - Buffered write: wen=1, widx=pend_idx, wdata=buffer.
  - wb_ctrl_stall = ex_wb_inst_vld (blanket stall).
  - Next state IDLE unconditionally.
- Writes to index 0 are never issued.
- lsu_wb_data_vld outside PEND is ignored.

Optional Feature:
CR_IU_WB_LOAD_FWD_EN
- Defined, return cycle (good data, pend_idx!=0):
  - wb_fwd_vld=1, wb_fwd_data=lsu_wb_data.
  - The source-match terms of H are suppressed that cycle, so a RAW consumer proceeds with 0 extra cycles.
  - The dst-match term is retained.
- Undefined:
  - wb_fwd_vld and wb_fwd_data are tied 0.
  - H holds through the return cycle; a RAW consumer issues the cycle after the RF write.

Test Plan:
1. Reset release, ex_wb_alu_vld=1, dst=5, data=0x1234 -> same cycle wen=1, widx=5, wdata=0x1234; stall=0; busy=0.
2. Load issue dst=7, next EX reads src0=7 for 3 cycles, data 0xCAFE returns in cycle 3:
   - stall=1 in cycles 1-2;
   - cycle 3: wen=1, widx=7, wdata=0xCAFE;
   - with FWD_EN: stall=0 and fwd_vld=1 in cycle 3; without FWD_EN: stall=1 in cycle 3 and 0 in cycle 4.
3. Load dst=3 pending; EX ALU dst=9 returns in the same cycle as load data 0x55:
   - cycle: widx=9, state->WRBK;
   - next cycle: widx=3, wdata=0x55, stall=ex_wb_inst_vld;
   - then IDLE.
4. Load pending, second load in EX -> stall until the return cycle; issue in the return cycle -> state stays PEND with the new pend_idx; busy stays 1.
5. Load dst=4 returns with lsu_wb_expt=1 -> no write, IDLE, stall on a src=4 consumer drops the same cycle.
6. cpurst_b=0 for one cycle while in PEND, then stray lsu_wb_data_vld -> no write, busy=0, all outputs 0.
